// File: rtl/logic_op_pkg.sv
// logic_op_pkg: op codes, op type and FSM states shared by the logic-op arbiter files.
package logic_op_pkg;
    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_NAND    = 3'd2;
    localparam logic [2:0] OP_NOR     = 3'd3;
    localparam logic [2:0] OP_XNOR    = 3'd4;
    localparam logic [2:0] OP_XOR     = 3'd5;
    localparam logic [2:0] OP_NOTA    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;
    typedef logic [2:0] op_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/logic_unit.sv
// logic_unit: combinational W-bit bitwise op evaluation; illegal op yields zero with err.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int W = 8
) (
    input  op_t          op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o,
    output logic         err_o
);
    always_comb begin
        res_o = '0;
        err_o = (op_i == OP_ILLEGAL);
        case (op_i)
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_NAND: res_o = ~(a_i & b_i);
            OP_NOR:  res_o = ~(a_i | b_i);
            OP_XNOR: res_o = ~(a_i ^ b_i);
            OP_XOR:  res_o = a_i ^ b_i;
            OP_NOTA: res_o = ~a_i;
            default: res_o = '0;
        endcase
    end
endmodule

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin sharing of one logic_unit among N requesters with a registered response.
// Define LOGIC_OP_ARBITER_STATS_EN to add per-requester 16-bit saturating grant counters.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [3*N-1:0] req_op,
    input  logic [W*N-1:0] req_a,
    input  logic [W*N-1:0] req_b,
    output logic [N-1:0]   resp_valid,
    input  logic [N-1:0]   resp_ready,
    output logic [W-1:0]   resp_data,
    output logic [IDW-1:0] resp_id,
    output logic           resp_err
`ifdef LOGIC_OP_ARBITER_STATS_EN
    ,
    input  logic            stat_clr,
    output logic [16*N-1:0] stat_cnt
`endif
);
    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, id_q, rid_q, g;
    op_t            op_q;
    logic [W-1:0]   a_q, b_q, data_q, res;
    logic           err_q, err, hit;

    // Descending scan so the lowest offset from the pointer is the final winner.
    always_comb begin
        g   = '0;
        hit = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_q) + k) % N]) begin
                g   = IDW'((int'(rr_q) + k) % N);
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (hit ? EXEC : IDLE) :
                  (state_q == EXEC) ? RESP :
                  (resp_ready[id_q] ? IDLE : RESP);
    end

    assign req_ready  = (rst_n && state_q == IDLE && hit) ? N'(1) << g : '0;
    assign resp_valid = (state_q == RESP) ? N'(1) << id_q : '0;
    assign resp_data  = data_q;
    assign resp_id    = rid_q;
    assign resp_err   = err_q;

    logic_unit #(.W(W)) u_logic_unit (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .res_o (res),
        .err_o (err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            rid_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && hit) begin
                id_q <= g;
                op_q <= req_op[3*g +: 3];
                a_q  <= req_a[W*g +: W];
                b_q  <= req_b[W*g +: W];
            end
            if (state_q == EXEC) begin
                data_q <= res;
                err_q  <= err;
                rid_q  <= id_q;
            end
            if (state_q == RESP && resp_ready[id_q])
                rr_q <= (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
        end
    end

`ifdef LOGIC_OP_ARBITER_STATS_EN
    logic [15:0] cnt_q [N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n || stat_clr)
                cnt_q[i] <= '0;
            else if (req_ready[i] && cnt_q[i] != 16'hFFFF)
                cnt_q[i] <= cnt_q[i] + 16'd1;
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < N; i++) stat_cnt[16*i +: 16] = cnt_q[i];
    end
`endif
endmodule
